// File: rtl/seg_bank_writer.sv
// seg_bank_writer: fills a shadow bank of segment patterns and commits it atomically to bank_out.
// Rev 1.0 -- optional marquee shift writes enabled by defining SHIFT_MODE_EN.
`default_nettype none

module seg_bank_writer #(
  parameter int                SLOTS = 5,
  parameter int                SEG_W = 7,
  parameter logic [SEG_W-1:0]  BLANK = {SEG_W{1'b0}},
  localparam int               PTR_W = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [SEG_W-1:0]         wr_data,
  input  logic                     wr_last,
  input  logic                     clear,
`ifdef SHIFT_MODE_EN
  input  logic                     shift_mode,
`endif
  output logic [PTR_W-1:0]         wr_ptr,
  output logic [SLOTS*SEG_W-1:0]   bank_out,
  output logic                     bank_valid
);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    CLEAR  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(SLOTS - 1);

  state_t                   state_q, state_d;
  logic [PTR_W-1:0]         ptr_q, ptr_d;
  logic [PTR_W-1:0]         cnt_q, cnt_d;
  logic [SEG_W-1:0]         shadow_q [SLOTS];
  logic [SEG_W-1:0]         shadow_d [SLOTS];
  logic [SLOTS*SEG_W-1:0]   bank_q, bank_d;
  logic                     valid_q, valid_d;
  logic                     wr_fire;
  logic                     shift_en;

`ifdef SHIFT_MODE_EN
  assign shift_en = shift_mode;
`else
  assign shift_en = 1'b0;
`endif

  // Ready is gated by rst_n so nothing is accepted while reset is held.
  assign wr_ready   = rst_n & (state_q == FILL) & ~clear;
  assign wr_fire    = wr_valid & wr_ready;
  assign wr_ptr     = ptr_q;
  assign bank_out   = bank_q;
  assign bank_valid = valid_q;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    bank_d   = bank_q;
    valid_d  = 1'b0;
    shadow_d = shadow_q;

    case (state_q)
      FILL: begin
        if (clear) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (wr_fire) begin
          if (shift_en) begin
            for (int k = 0; k < SLOTS - 1; k++) begin
              shadow_d[k] = shadow_q[k+1];
            end
            shadow_d[SLOTS-1] = wr_data;
            ptr_d   = '0;
            state_d = COMMIT;
          end else begin
            shadow_d[ptr_q] = wr_data;
            ptr_d = (ptr_q == LAST_SLOT) ? '0 : ptr_q + PTR_W'(1);
            if (wr_last || (ptr_q == LAST_SLOT)) begin
              state_d = COMMIT;
            end
          end
        end
      end

      CLEAR: begin
        shadow_d[cnt_q] = BLANK;
        if (cnt_q == LAST_SLOT) begin
          cnt_d   = '0;
          state_d = COMMIT;
        end else begin
          cnt_d = cnt_q + PTR_W'(1);
        end
      end

      COMMIT: begin
        // Slot 0 occupies the most significant field of the bus.
        for (int k = 0; k < SLOTS; k++) begin
          bank_d[(SLOTS-1-k)*SEG_W +: SEG_W] = shadow_q[k];
        end
        valid_d = 1'b1;
        ptr_d   = '0;
        state_d = FILL;
      end

      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FILL;
      ptr_q   <= '0;
      cnt_q   <= '0;
      bank_q  <= {SLOTS{BLANK}};
      valid_q <= 1'b0;
      for (int k = 0; k < SLOTS; k++) begin
        shadow_q[k] <= BLANK;
      end
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      bank_q   <= bank_d;
      valid_q  <= valid_d;
      shadow_q <= shadow_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg_bank_writer.sv
// tb_seg_bank_writer: directed vectors with hand-computed expectations for seg_bank_writer.
// Rev 1.0 -- shift-mode vectors run only when SHIFT_MODE_EN is defined.
`default_nettype none

module tb_seg_bank_writer;

  logic        clk;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [6:0]  wr_data;
  logic        wr_last;
  logic        clear;
  logic [2:0]  wr_ptr;
  logic [34:0] bank_out;
  logic        bank_valid;
`ifdef SHIFT_MODE_EN
  logic        shift_mode;
`endif

  int n_checks;
  int n_errors;

  seg_bank_writer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .wr_last    (wr_last),
    .clear      (clear),
`ifdef SHIFT_MODE_EN
    .shift_mode (shift_mode),
`endif
    .wr_ptr     (wr_ptr),
    .bank_out   (bank_out),
    .bank_valid (bank_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [34:0] obs, input logic [34:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs settle 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [6:0] d, input logic last);
    wr_valid = 1'b1;
    wr_data  = d;
    wr_last  = last;
    tick();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  logic [34:0] exp_bank;
  logic [6:0]  digits [5];
  int          pulses;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = 7'h00;
    wr_last  = 1'b0;
    clear    = 1'b0;
`ifdef SHIFT_MODE_EN
    shift_mode = 1'b0;
`endif
    digits[0] = 7'h06; digits[1] = 7'h5B; digits[2] = 7'h4F;
    digits[3] = 7'h66; digits[4] = 7'h6D;

    tick();
    tick();
    check_val("ready_in_reset", {34'd0, wr_ready}, 35'd0);
    rst_n = 1'b1;
    #1;
    check_val("rst_bank", bank_out, 35'h0);
    check_val("rst_ptr", {32'd0, wr_ptr}, 35'd0);
    check_val("rst_valid", {34'd0, bank_valid}, 35'd0);
    check_val("rst_ready", {34'd0, wr_ready}, 35'd1);

    // Five back-to-back writes; the fifth lands in the last slot and commits.
    for (int i = 0; i < 5; i++) begin
      check_val("fill_ready", {34'd0, wr_ready}, 35'd1);
      put(digits[i], 1'b0);
      if (i == 0) check_val("ptr_after_first", {32'd0, wr_ptr}, 35'd1);
    end
    check_val("commit_ready_low", {34'd0, wr_ready}, 35'd0);
    check_val("commit_valid_not_yet", {34'd0, bank_valid}, 35'd0);
    check_val("bank_stable_before_commit", bank_out, 35'h0);
    tick();
    exp_bank = {7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D};
    check_val("bank_five", bank_out, exp_bank);
    check_val("valid_five", {34'd0, bank_valid}, 35'd1);
    check_val("ptr_five", {32'd0, wr_ptr}, 35'd0);
    check_val("ready_after_commit", {34'd0, wr_ready}, 35'd1);
    tick();
    check_val("valid_drop_five", {34'd0, bank_valid}, 35'd0);

    // Early commit with wr_last; untouched slots retain their old patterns.
    put(7'h3F, 1'b1);
    check_val("last_valid_not_yet", {34'd0, bank_valid}, 35'd0);
    tick();
    exp_bank = {7'h3F, 7'h5B, 7'h4F, 7'h66, 7'h6D};
    check_val("bank_last", bank_out, exp_bank);
    check_val("valid_last", {34'd0, bank_valid}, 35'd1);
    check_val("ptr_last", {32'd0, wr_ptr}, 35'd0);
    tick();
    check_val("valid_drop_last", {34'd0, bank_valid}, 35'd0);

    // Clear wins over a same-cycle write.
    clear    = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 7'h7F;
    #1;
    check_val("clear_blocks_ready", {34'd0, wr_ready}, 35'd0);
    tick();
    clear    = 1'b0;
    wr_valid = 1'b0;
    check_val("clear_write_rejected", {32'd0, wr_ptr}, 35'd0);
    for (int i = 0; i < 6; i++) begin
      check_val("clear_ready_low", {34'd0, wr_ready}, 35'd0);
      check_val("clear_no_valid", {34'd0, bank_valid}, 35'd0);
      check_val("clear_bank_held", bank_out, exp_bank);
      tick();
    end
    check_val("clear_bank", bank_out, 35'h0);
    check_val("clear_valid", {34'd0, bank_valid}, 35'd1);
    check_val("clear_ready_back", {34'd0, wr_ready}, 35'd1);
    tick();
    check_val("clear_valid_drop", {34'd0, bank_valid}, 35'd0);

    // Reset during the third clear cycle aborts the clear without a commit.
    put(7'h06, 1'b1);
    tick();
    check_val("pre_abort_bank", bank_out, {7'h06, 28'h0});
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check_val("abort_ready_in_reset", {34'd0, wr_ready}, 35'd0);
    rst_n = 1'b1;
    #1;
    check_val("abort_ready_fill", {34'd0, wr_ready}, 35'd1);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (bank_valid) pulses++;
      tick();
    end
    check_val("abort_no_pulse", 35'(pulses), 35'd0);
    check_val("abort_bank", bank_out, 35'h0);
    check_val("abort_ptr", {32'd0, wr_ptr}, 35'd0);

`ifdef SHIFT_MODE_EN
    for (int i = 0; i < 5; i++) put(digits[i], 1'b0);
    tick();
    check_val("shift_base", bank_out, {7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D});
    tick();
    shift_mode = 1'b1;
    pulses = 0;
    put(7'h77, 1'b0);
    check_val("shift_ptr_hold", {32'd0, wr_ptr}, 35'd0);
    check_val("shift_ready_low", {34'd0, wr_ready}, 35'd0);
    tick();
    if (bank_valid) pulses++;
    check_val("shift_bank1", bank_out, {7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h77});
    tick();
    put(7'h7C, 1'b0);
    tick();
    if (bank_valid) pulses++;
    check_val("shift_bank2", bank_out, {7'h4F, 7'h66, 7'h6D, 7'h77, 7'h7C});
    check_val("shift_pulses", 35'(pulses), 35'd2);
    tick();
    check_val("shift_valid_drop", {34'd0, bank_valid}, 35'd0);
    shift_mode = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
